// File: rtl/led_result_display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants for the LED result display stage: display state
// encodings (also driven out on the mode port) and the LED bank width.
// ---------------------------------------------------------------------------
package display_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_DATA = 2'd1,
    ST_SHOW_PAR  = 2'd2
  } state_t;

endpackage : display_pkg

// File: rtl/led_result_display_if.sv
// ---------------------------------------------------------------------------
// led_result_display_if
// Groups the compute-stage result handshake and the LED-side outputs.
//   data_valid : one-cycle pulse, data_in/parity_in are final
//   data_in    : accumulated XOR result
//   parity_in  : upstream XOR-reduction of data_in
//   led        : LED drive, led[7] is the MSB
//   mode       : current display state encoding
//   parity_err : captured parity disagrees with captured data
// master : the compute side (drives the result, observes the display)
// slave  : the display stage
// ---------------------------------------------------------------------------
interface led_result_display_if;
  import display_pkg::*;

  logic             data_valid;
  logic [LED_W-1:0] data_in;
  logic             parity_in;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic             parity_err;

  modport master (
    output data_valid, data_in, parity_in,
    input  led, mode, parity_err
  );

  modport slave (
    input  data_valid, data_in, parity_in,
    output led, mode, parity_err
  );

endinterface : led_result_display_if

// File: rtl/led_result_display_pb_debounce.sv
// ---------------------------------------------------------------------------
// pb_debounce
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector. Reusable by any button-driven lab.
//   clk    : sole clock
//   rst    : asynchronous, active-high reset
//   pb     : raw, bouncing, asynchronous button input
//   pb_deb : debounced button level
//   press  : one-cycle pulse on each debounced rising edge
// A level change is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current debounced level.
// ---------------------------------------------------------------------------
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_deb,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_pb_sync;
  logic             r_pb_deb;
  logic             r_pb_deb_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_pb_sync <= 1'b0;
    end else begin
      r_sync1   <= pb;
      r_pb_sync <= r_sync1;
    end
  end

  // The D-th consecutive differing sample flips the level, so the counter
  // tops out at D-1 and can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_pb_deb   <= 1'b0;
      r_pb_deb_d <= 1'b0;
    end else begin
      r_pb_deb_d <= r_pb_deb;
      if (r_pb_sync == r_pb_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_pb_deb <= ~r_pb_deb;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pb_deb = r_pb_deb;
  assign press  = r_pb_deb & ~r_pb_deb_d;

endmodule : pb_debounce

// File: rtl/led_result_display.sv
// ---------------------------------------------------------------------------
// led_result_display
// Output stage of the XOR/parity pipeline. Captures the result byte and its
// parity on data_valid, checks the parity, and drives the LEDs with either
// the result byte or the parity bit, alternating on each debounced press.
//   clk : sole clock
//   rst : asynchronous, active-high reset
//   pb  : raw push button
//   bus : result handshake in, led/mode/parity_err out (all registered)
// ---------------------------------------------------------------------------
module led_result_display
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pb,
  led_result_display_if.slave  bus
);

  logic             w_press;
  logic             w_pb_deb;
  logic             w_par_calc;

  logic [LED_W-1:0] r_data_q;
  logic             r_par_q;
  logic             r_parity_err;
  logic [LED_W-1:0] r_led;
  state_t           r_state;

  pb_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pb_debounce (
    .clk    (clk),
    .rst    (rst),
    .pb     (pb),
    .pb_deb (w_pb_deb),
    .press  (w_press)
  );

  // Parity check uses the incoming values so the flag lands with the capture.
  assign w_par_calc = bus.parity_in ^ (^bus.data_in);

  // data_valid has priority over press in every state; a coincident press
  // is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q     <= '0;
      r_par_q      <= 1'b0;
      r_parity_err <= 1'b0;
      r_led        <= '0;
      r_state      <= ST_IDLE;
    end else if (bus.data_valid) begin
      r_data_q     <= bus.data_in;
      r_par_q      <= bus.parity_in;
      r_parity_err <= w_par_calc;
      r_led        <= bus.data_in;
      r_state      <= ST_SHOW_DATA;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_led <= '0;
        end
        ST_SHOW_DATA: begin
          if (w_press) begin
            r_state <= ST_SHOW_PAR;
            r_led   <= {{(LED_W-1){1'b0}}, r_par_q};
          end
        end
        ST_SHOW_PAR: begin
          if (w_press) begin
            r_state <= ST_SHOW_DATA;
            r_led   <= r_data_q;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= '0;
        end
      endcase
    end
  end

  assign bus.led        = r_led;
  assign bus.mode       = r_state;
  assign bus.parity_err = r_parity_err;

endmodule : led_result_display

// File: tb/tb_led_result_display.sv
// ---------------------------------------------------------------------------
// tb_led_result_display
// Directed bench for led_result_display with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_led_result_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pb  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  led_result_display_if bus_if ();

  led_result_display #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pb  (pb),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = d;
    bus_if.parity_in  = p;
    step(1);
    bus_if.data_valid = 1'b0;
  endtask

  task automatic test_reset_state();
    n_tests++;
    if (bus_if.led !== 8'h00 || bus_if.mode !== 2'd0 || bus_if.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: led=%h mode=%0d perr=%b, want 00/0/0",
               bus_if.led, bus_if.mode, bus_if.parity_err);
    end
  endtask

  task automatic test_idle_after_reset();
    // Button held through reset release: one press, ignored in IDLE.
    pb  = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(12);
    n_tests++;
    if (bus_if.led !== 8'h00 || bus_if.mode !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_held_press: led=%h mode=%0d, want 00/0", bus_if.led, bus_if.mode);
    end
    pb = 1'b0;
    step(10);
    // Fresh press in IDLE is ignored too.
    pb = 1'b1;
    step(12);
    pb = 1'b0;
    step(10);
    n_tests++;
    if (bus_if.led !== 8'h00 || bus_if.mode !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_press: led=%h mode=%0d, want 00/0", bus_if.led, bus_if.mode);
    end
  endtask

  task automatic test_capture();
    send(8'hA5, 1'b0);
    n_tests++;
    if (bus_if.led !== 8'hA5 || bus_if.mode !== 2'd1 || bus_if.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL capture: led=%h mode=%0d perr=%b, want a5/1/0",
               bus_if.led, bus_if.mode, bus_if.parity_err);
    end
    // pb first sampled at edge N; toggle lands after edge N+6.
    pb = 1'b1;
    step(6);
    n_tests++;
    if (bus_if.mode !== 2'd1 || bus_if.led !== 8'hA5) begin
      n_fail++;
      $display("FAIL press_early: led=%h mode=%0d, want a5/1", bus_if.led, bus_if.mode);
    end
    step(1);
    n_tests++;
    if (bus_if.mode !== 2'd2 || bus_if.led !== 8'h00) begin
      n_fail++;
      $display("FAIL press_latency: led=%h mode=%0d, want 00/2", bus_if.led, bus_if.mode);
    end
    // Holding the button does not toggle again.
    step(20);
    n_tests++;
    if (bus_if.mode !== 2'd2) begin
      n_fail++;
      $display("FAIL press_hold: mode=%0d, want 2", bus_if.mode);
    end
    pb = 1'b0;
    step(10);
    pb = 1'b1;
    step(10);
    n_tests++;
    if (bus_if.mode !== 2'd1 || bus_if.led !== 8'hA5) begin
      n_fail++;
      $display("FAIL second_press: led=%h mode=%0d, want a5/1", bus_if.led, bus_if.mode);
    end
    pb = 1'b0;
    step(10);
  endtask

  task automatic test_bounce();
    // Start in SHOW_DATA showing A5.
    pb = 1'b1; step(1);
    pb = 1'b0; step(1);
    pb = 1'b1; step(1);
    pb = 1'b0; step(1);
    pb = 1'b1; step(10);
    n_tests++;
    if (bus_if.mode !== 2'd2 || bus_if.led !== 8'h00) begin
      n_fail++;
      $display("FAIL bounce_one_toggle: led=%h mode=%0d, want 00/2", bus_if.led, bus_if.mode);
    end
    step(10);
    n_tests++;
    if (bus_if.mode !== 2'd2) begin
      n_fail++;
      $display("FAIL bounce_no_extra: mode=%0d, want 2", bus_if.mode);
    end
    pb = 1'b0;
    step(10);
    pb = 1'b1; step(3);
    pb = 1'b0; step(12);
    n_tests++;
    if (bus_if.mode !== 2'd2 || bus_if.led !== 8'h00) begin
      n_fail++;
      $display("FAIL short_pulse: led=%h mode=%0d, want 00/2", bus_if.led, bus_if.mode);
    end
  endtask

  task automatic test_collision();
    // Entering in SHOW_PAR; press pulse is sampled at edge N+6 together
    // with data_valid.
    pb = 1'b1;
    step(6);
    send(8'h3C, 1'b0);
    n_tests++;
    if (bus_if.led !== 8'h3C || bus_if.mode !== 2'd1) begin
      n_fail++;
      $display("FAIL collision: led=%h mode=%0d, want 3c/1", bus_if.led, bus_if.mode);
    end
    step(10);
    n_tests++;
    if (bus_if.led !== 8'h3C || bus_if.mode !== 2'd1) begin
      n_fail++;
      $display("FAIL collision_dropped: led=%h mode=%0d, want 3c/1", bus_if.led, bus_if.mode);
    end
    pb = 1'b0;
    step(10);
  endtask

  task automatic test_parity();
    send(8'h07, 1'b0);
    n_tests++;
    if (bus_if.parity_err !== 1'b1 || bus_if.led !== 8'h07) begin
      n_fail++;
      $display("FAIL parity_err_set: perr=%b led=%h, want 1/07", bus_if.parity_err, bus_if.led);
    end
    // Parity view shows the captured parity bit.
    pb = 1'b1;
    step(10);
    pb = 1'b0;
    n_tests++;
    if (bus_if.mode !== 2'd2 || bus_if.led !== 8'h00) begin
      n_fail++;
      $display("FAIL parity_view0: led=%h mode=%0d, want 00/2", bus_if.led, bus_if.mode);
    end
    step(10);
    send(8'h07, 1'b1);
    n_tests++;
    if (bus_if.parity_err !== 1'b0 || bus_if.mode !== 2'd1) begin
      n_fail++;
      $display("FAIL parity_err_clear: perr=%b mode=%0d, want 0/1", bus_if.parity_err, bus_if.mode);
    end
    pb = 1'b1;
    step(10);
    pb = 1'b0;
    n_tests++;
    if (bus_if.mode !== 2'd2 || bus_if.led !== 8'h01) begin
      n_fail++;
      $display("FAIL parity_view1: led=%h mode=%0d, want 01/2", bus_if.led, bus_if.mode);
    end
    step(10);
  endtask

  task automatic test_reset();
    send(8'h07, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus_if.led !== 8'h00 || bus_if.mode !== 2'd0 || bus_if.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: led=%h mode=%0d perr=%b, want 00/0/0",
               bus_if.led, bus_if.mode, bus_if.parity_err);
    end
    step(2);
    rst = 1'b0;
    pb  = 1'b0;
    step(12);
    n_tests++;
    if (bus_if.led !== 8'h00 || bus_if.mode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: led=%h mode=%0d, want 00/0", bus_if.led, bus_if.mode);
    end
  endtask

  initial begin
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 8'h00;
    bus_if.parity_in  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    test_reset_state();
    step(2);
    rst = 1'b0;
    step(1);
    test_reset_state();
    test_idle_after_reset();
    test_capture();
    test_bounce();
    test_collision();
    test_parity();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_result_display
